// File: rtl/nes_joypad_port.sv
// NES $4016/$4017 controller port emulation for two players fed by SNES button vectors.
// Strobe latch, one-bit-per-read serial shift, and optional 30 Hz turbo on A/B.
module nes_joypad_port #(
   parameter int TURBO_DIV = 833333
) (
   input  logic        CLOCK,
   input  logic        RESET,
   input  logic [11:0] BUTTONS1,
   input  logic [11:0] BUTTONS2,
   input  logic        TURBO_EN,
   input  logic        REG_SEL,
   input  logic        WR_EN,
   input  logic [7:0]  WR_DATA,
   input  logic        RD_EN,
   input  logic [2:0]  OPEN_BUS,
   output logic [7:0]  RD_DATA,
   output logic        STROBE
);

   localparam int             CW   = $clog2(TURBO_DIV);
   localparam logic [CW-1:0]  TMAX = CW'(TURBO_DIV - 1);

   logic          r_strobe;
   logic [7:0]    r_sr1, r_sr2;
   logic [7:0]    r_rd_data;
   logic [CW-1:0] r_turbo_cnt;
   logic          r_turbo_phase;
   logic          r_rd_prev;

   logic          w_turbo;
   logic          w_rd_start;
   logic          w_sel_bit;
   logic [7:0]    w_map1, w_map2;
   logic          w_unused_in;

   // SNES order in, NES order out (bit 0 shifted first); X/Y double as turbo A/B.
   function automatic logic [7:0] map_btn(input logic [11:0] b, input logic t);
      return {b[7], b[6], b[5], b[4], b[3], b[2], b[0] | (b[1] & t), b[8] | (b[9] & t)};
   endfunction

   assign w_turbo     = r_turbo_phase & TURBO_EN;
   assign w_map1      = map_btn(BUTTONS1, w_turbo);
   assign w_map2      = map_btn(BUTTONS2, w_turbo);
   assign w_rd_start  = RD_EN & ~r_rd_prev;
   assign w_sel_bit   = REG_SEL ? r_sr2[0] : r_sr1[0];
   assign w_unused_in = &{1'b0, WR_DATA[7:1], BUTTONS1[11:10], BUTTONS2[11:10]};

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         r_strobe      <= 1'b0;
         r_sr1         <= 8'h00;
         r_sr2         <= 8'h00;
         r_rd_data     <= 8'h00;
         r_turbo_cnt   <= '0;
         r_turbo_phase <= 1'b0;
         r_rd_prev     <= 1'b0;
      end else begin
         r_rd_prev <= RD_EN;

         // $4017 writes go to the APU, so only $4016 touches the latch.
         if (WR_EN && !REG_SEL)
            r_strobe <= WR_DATA[0];

         if (r_turbo_cnt == TMAX) begin
            r_turbo_cnt   <= '0;
            r_turbo_phase <= ~r_turbo_phase;
         end else begin
            r_turbo_cnt <= r_turbo_cnt + 1'b1;
         end

         // Registered strobe governs this cycle, so a 1->0 write still reloads once.
         if (r_strobe) begin
            r_sr1 <= w_map1;
            r_sr2 <= w_map2;
         end else if (w_rd_start) begin
            if (REG_SEL)
               r_sr2 <= {1'b1, r_sr2[7:1]};
            else
               r_sr1 <= {1'b1, r_sr1[7:1]};
         end

         if (w_rd_start)
            r_rd_data <= {OPEN_BUS, 4'b0000, w_sel_bit};
      end
   end

   assign RD_DATA = r_rd_data;
   assign STROBE  = r_strobe;

endmodule

// File: tb/tb_nes_joypad_port.sv
// Scoreboard bench for nes_joypad_port: stimulus pushes expected read data, a monitor
// pops and compares one cycle after each detected read start.
module tb_nes_joypad_port;

   logic        CLOCK = 1'b0;
   logic        RESET = 1'b1;
   logic [11:0] BUTTONS1 = '0, BUTTONS2 = '0;
   logic        TURBO_EN = 1'b0, REG_SEL = 1'b0, WR_EN = 1'b0, RD_EN = 1'b0;
   logic [7:0]  WR_DATA = '0;
   logic [2:0]  OPEN_BUS = '0;
   logic [7:0]  RD_DATA;
   logic        STROBE;

   nes_joypad_port #(.TURBO_DIV(4)) dut (
      .CLOCK(CLOCK), .RESET(RESET), .BUTTONS1(BUTTONS1), .BUTTONS2(BUTTONS2),
      .TURBO_EN(TURBO_EN), .REG_SEL(REG_SEL), .WR_EN(WR_EN), .WR_DATA(WR_DATA),
      .RD_EN(RD_EN), .OPEN_BUS(OPEN_BUS), .RD_DATA(RD_DATA), .STROBE(STROBE)
   );

   always #5 CLOCK = ~CLOCK;

   typedef struct { string nm; logic [7:0] v; } exp_t;
   exp_t q[$];
   int   checks = 0, errors = 0;
   int   tcnt = 0;
   logic mon_prev = 1'b0, mon_pend = 1'b0;

   // Cycles since the last reset edge, used to predict turbo phase.
   always @(posedge CLOCK) tcnt <= RESET ? 0 : tcnt + 1;

   always @(posedge CLOCK) begin
      mon_pend <= !RESET && RD_EN && !mon_prev;
      mon_prev <= RESET ? 1'b0 : RD_EN;
   end

   always @(negedge CLOCK) begin
      if (mon_pend) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_read got %h required none", RD_DATA);
         end else begin
            exp_t e;
            e = q.pop_front();
            if (RD_DATA !== e.v) begin
               errors++;
               $display("FAIL %s got %h required %h", e.nm, RD_DATA, e.v);
            end
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge CLOCK);
   endtask

   task automatic wr(input logic sel, input logic d);
      REG_SEL = sel; WR_DATA = {7'h55, d}; WR_EN = 1'b1;
      cyc(1);
      WR_EN = 1'b0;
   endtask

   task automatic rd(input string nm, input logic sel, input logic [7:0] v, input int hold = 1);
      exp_t e;
      e.nm = nm; e.v = v;
      q.push_back(e);
      REG_SEL = sel; RD_EN = 1'b1;
      cyc(hold);
      RD_EN = 1'b0;
      cyc(1);
   endtask

   task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s got %h required %h", nm, got, req);
      end
   endtask

   task automatic latch();
      wr(0, 1'b1); cyc(2); wr(0, 1'b0); cyc(1);
   endtask

   logic [7:0] seq1 [10] = '{8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01};

   initial begin
      cyc(3);
      chk("reset_strobe", {7'b0, STROBE}, 8'h00);
      chk("reset_rd_data", RD_DATA, 8'h00);
      RESET = 1'b0;
      cyc(2);

      // Basic latch and read: A|Start
      BUTTONS1 = 12'h108;
      latch();
      chk("strobe_low_after_latch", {7'b0, STROBE}, 8'h00);
      for (int i = 0; i < 10; i++) rd($sformatf("basic_rd%0d", i), 0, seq1[i]);

      // Held read counts once; Select=1 would show up on an extra shift.
      BUTTONS1 = 12'h104;
      latch();
      rd("held_rd_A", 0, 8'h01, 5);
      rd("held_rd_B", 0, 8'h00);

      // Strobe held high: live A, no shifting
      wr(0, 1'b1);
      chk("strobe_high", {7'b0, STROBE}, 8'h01);
      BUTTONS1 = 12'h100; cyc(2); rd("strobe_hi_rd0", 0, 8'h01);
      BUTTONS1 = 12'h000; cyc(2); rd("strobe_hi_rd1", 0, 8'h00);
      BUTTONS1 = 12'h100; cyc(2); rd("strobe_hi_rd2", 0, 8'h01);
      wr(0, 1'b0); cyc(1);
      rd("freeze_A", 0, 8'h01);
      rd("freeze_B", 0, 8'h00);

      // Player 2 independence and open bus
      OPEN_BUS = 3'b010;
      BUTTONS1 = 12'h108;
      BUTTONS2 = 12'h080;
      latch();
      for (int i = 0; i < 7; i++) rd($sformatf("p2_rd%0d", i), 1, 8'h40);
      rd("p2_rd7_right", 1, 8'h41);
      rd("p1_untouched_A", 0, 8'h41);
      rd("p1_untouched_B", 0, 8'h40);

      // $4017 write must not touch the strobe
      wr(1, 1'b1); cyc(1);
      chk("wr4017_ignored", {7'b0, STROBE}, 8'h00);

      // Reset mid-read
      BUTTONS1 = 12'hFFF;
      latch();
      for (int i = 0; i < 3; i++) rd($sformatf("pre_rst_rd%0d", i), 0, 8'h41);
      RESET = 1'b1; cyc(1); RESET = 1'b0;
      chk("rst_mid_strobe", {7'b0, STROBE}, 8'h00);
      chk("rst_mid_rd_data", RD_DATA, 8'h00);
      for (int i = 0; i < 8; i++) rd($sformatf("post_rst_rd%0d", i), 0, 8'h40);
      rd("post_rst_rd8", 0, 8'h41);

      // Turbo: X pressed, strobe held high, one read per 4-cycle window.
      // Read starting on edge j captures the reload from edge j-1, i.e. phase after edge j-2.
      OPEN_BUS = 3'b000;
      BUTTONS1 = 12'h200;
      TURBO_EN = 1'b1;
      RESET = 1'b1; cyc(1); RESET = 1'b0;
      wr(0, 1'b1); cyc(3);
      for (int i = 0; i < 6; i++) begin
         rd($sformatf("turbo_rd%0d", i), 0, {7'b0, 1'(((tcnt - 1) / 4) % 2)});
         cyc(2);
      end
      TURBO_EN = 1'b0; cyc(2);
      for (int i = 0; i < 4; i++) begin
         rd($sformatf("turbo_off_rd%0d", i), 0, 8'h00);
         cyc(2);
      end

      for (int i = 0; i < 20 && q.size() != 0; i++) cyc(1);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got %0d required 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
